// File: rtl/privtrapseq.sv
// ============================================================================
// Module   : privtrapseq
// Purpose  : Privilege-transition sequencer: trap/mret/sret drain-commit-redirect
// Revision : 1.0
// ============================================================================
`default_nettype none

module privtrapseq #(
    parameter int XLEN        = 64,
    parameter bit S_SUPPORTED = 1'b1,
    parameter bit U_SUPPORTED = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            TrapReqM,
    input  logic            InterruptM,
    input  logic [3:0]      CauseM,
    input  logic            MretReqM,
    input  logic            SretReqM,
    input  logic [1:0]      STATUS_MPP,
    input  logic            STATUS_SPP,
    input  logic            STATUS_TSR,
    input  logic [15:0]     MEDELEG_REGW,
    input  logic [11:0]     MIDELEG_REGW,
    input  logic [XLEN-1:0] MTVEC_REGW,
    input  logic [XLEN-1:0] STVEC_REGW,
    input  logic [XLEN-1:0] MEPC_REGW,
    input  logic [XLEN-1:0] SEPC_REGW,
    input  logic            PipeEmpty,
    input  logic            StallW,
    input  logic            RedirectReady,
    output logic [1:0]      PrivilegeModeW,
    output logic            TrapM,
    output logic            mretM,
    output logic            sretM,
    output logic            NextPrivModeIsM,
    output logic [XLEN-1:0] TrapCauseM,
    output logic            FlushReq,
    output logic            RedirectValid,
    output logic [XLEN-1:0] RedirectPC,
    output logic            Busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAIN    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } state_t;

    localparam logic [1:0] c_MODE_U    = 2'b00;
    localparam logic [1:0] c_MODE_S    = 2'b01;
    localparam logic [1:0] c_MODE_M    = 2'b11;
    localparam logic [1:0] c_KIND_TRAP = 2'd0;
    localparam logic [1:0] c_KIND_MRET = 2'd1;
    localparam logic [1:0] c_KIND_SRET = 2'd2;

    state_t            r_state;
    state_t            w_state_next;
    logic [1:0]        r_kind;
    logic [1:0]        r_next_mode;
    logic [1:0]        r_priv;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_cause;

    logic              w_capture;
    logic              w_mret_illegal;
    logic              w_sret_illegal;
    logic              w_is_trap;
    logic              w_int;
    logic [3:0]        w_cause;
    logic              w_deleg_bit;
    logic              w_to_s;
    logic [XLEN-1:0]   w_tvec;
    logic [XLEN-1:0]   w_base;
    logic [XLEN-1:0]   w_trap_pc;
    logic [XLEN-1:0]   w_trap_cause;
    logic [1:0]        w_mret_mode;
    logic [1:0]        w_kind;
    logic [1:0]        w_next_mode;
    logic [XLEN-1:0]   w_pc;

    // Illegal returns fold into a trap with interrupt=0, cause=2.
    assign w_mret_illegal = (r_priv != c_MODE_M);
    assign w_sret_illegal = (r_priv == c_MODE_U) || ((r_priv == c_MODE_S) && STATUS_TSR);
    assign w_is_trap      = TrapReqM
                          | (MretReqM & w_mret_illegal)
                          | (~MretReqM & SretReqM & w_sret_illegal);
    assign w_int          = TrapReqM & InterruptM;
    assign w_cause        = TrapReqM ? CauseM : 4'd2;
    assign w_capture      = (r_state == IDLE) && (TrapReqM || MretReqM || SretReqM);

    always_comb begin
        w_deleg_bit = 1'b0;
        if (w_int) begin
            if (w_cause < 4'd12) begin
                w_deleg_bit = MIDELEG_REGW[w_cause];
            end
        end else begin
            w_deleg_bit = MEDELEG_REGW[w_cause];
        end
    end

    assign w_to_s       = S_SUPPORTED && (r_priv != c_MODE_M) && w_deleg_bit;
    assign w_tvec       = w_to_s ? STVEC_REGW : MTVEC_REGW;
    assign w_base       = {w_tvec[XLEN-1:2], 2'b00};
    assign w_trap_pc    = (w_int && (w_tvec[1:0] == 2'b01))
                        ? (w_base + {{(XLEN-6){1'b0}}, w_cause, 2'b00})
                        : w_base;
    assign w_trap_cause = {w_int, {(XLEN-5){1'b0}}, w_cause};

    // An MPP naming an absent mode returns to M.
    always_comb begin
        w_mret_mode = c_MODE_M;
        case (STATUS_MPP)
            2'b01:   w_mret_mode = S_SUPPORTED ? c_MODE_S : c_MODE_M;
            2'b00:   w_mret_mode = U_SUPPORTED ? c_MODE_U : c_MODE_M;
            default: w_mret_mode = c_MODE_M;
        endcase
    end

    always_comb begin
        w_kind      = c_KIND_TRAP;
        w_next_mode = w_to_s ? c_MODE_S : c_MODE_M;
        w_pc        = w_trap_pc;
        if (!w_is_trap) begin
            if (MretReqM) begin
                w_kind      = c_KIND_MRET;
                w_next_mode = w_mret_mode;
                w_pc        = MEPC_REGW;
            end else begin
                w_kind      = c_KIND_SRET;
                w_next_mode = {1'b0, STATUS_SPP};
                w_pc        = SEPC_REGW;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_kind      <= c_KIND_TRAP;
            r_next_mode <= c_MODE_M;
            r_priv      <= c_MODE_M;
            r_pc        <= '0;
            r_cause     <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_kind      <= w_kind;
                r_next_mode <= w_next_mode;
                r_pc        <= w_pc;
                // The cause register only tracks trap captures; returns leave it intact.
                if (w_is_trap) begin
                    r_cause <= w_trap_cause;
                end
            end
            if ((r_state == COMMIT) && !StallW) begin
                r_priv <= r_next_mode;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        TrapM           = 1'b0;
        mretM           = 1'b0;
        sretM           = 1'b0;
        NextPrivModeIsM = 1'b0;
        FlushReq        = 1'b0;
        RedirectValid   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_capture) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                FlushReq = 1'b1;
                if (PipeEmpty && !StallW) begin
                    w_state_next = COMMIT;
                end
            end
            COMMIT: begin
                TrapM           = (r_kind == c_KIND_TRAP);
                mretM           = (r_kind == c_KIND_MRET);
                sretM           = (r_kind == c_KIND_SRET);
                NextPrivModeIsM = (r_next_mode == c_MODE_M);
                if (!StallW) begin
                    w_state_next = REDIRECT;
                end
            end
            REDIRECT: begin
                RedirectValid = 1'b1;
                if (RedirectReady) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign PrivilegeModeW = r_priv;
    assign TrapCauseM     = r_cause;
    assign RedirectPC     = r_pc;
    assign Busy           = (r_state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_privtrapseq.sv
// ============================================================================
// Module   : tb_privtrapseq
// Purpose  : Directed scoreboard bench for the privilege-transition sequencer
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_privtrapseq;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        TrapReqM = 1'b0, InterruptM = 1'b0, MretReqM = 1'b0, SretReqM = 1'b0;
    logic [3:0]  CauseM = '0;
    logic [1:0]  STATUS_MPP = '0;
    logic        STATUS_SPP = 1'b0, STATUS_TSR = 1'b0;
    logic [15:0] MEDELEG_REGW = '0;
    logic [11:0] MIDELEG_REGW = '0;
    logic [63:0] MTVEC_REGW = '0, STVEC_REGW = '0, MEPC_REGW = '0, SEPC_REGW = '0;
    logic        PipeEmpty = 1'b1, StallW = 1'b0, RedirectReady = 1'b1;
    logic [1:0]  PrivilegeModeW;
    logic        TrapM, mretM, sretM, NextPrivModeIsM, FlushReq, RedirectValid, Busy;
    logic [63:0] TrapCauseM, RedirectPC;

    privtrapseq #(.XLEN(64), .S_SUPPORTED(1'b1), .U_SUPPORTED(1'b1)) dut (
        .clk(clk), .reset(reset),
        .TrapReqM(TrapReqM), .InterruptM(InterruptM), .CauseM(CauseM),
        .MretReqM(MretReqM), .SretReqM(SretReqM),
        .STATUS_MPP(STATUS_MPP), .STATUS_SPP(STATUS_SPP), .STATUS_TSR(STATUS_TSR),
        .MEDELEG_REGW(MEDELEG_REGW), .MIDELEG_REGW(MIDELEG_REGW),
        .MTVEC_REGW(MTVEC_REGW), .STVEC_REGW(STVEC_REGW),
        .MEPC_REGW(MEPC_REGW), .SEPC_REGW(SEPC_REGW),
        .PipeEmpty(PipeEmpty), .StallW(StallW), .RedirectReady(RedirectReady),
        .PrivilegeModeW(PrivilegeModeW), .TrapM(TrapM), .mretM(mretM), .sretM(sretM),
        .NextPrivModeIsM(NextPrivModeIsM), .TrapCauseM(TrapCauseM),
        .FlushReq(FlushReq), .RedirectValid(RedirectValid), .RedirectPC(RedirectPC),
        .Busy(Busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  strobe;     // {TrapM, mretM, sretM}
        logic        nextm;
        logic        chk_cause;
        logic [63:0] cause;
        logic [63:0] pc;
        logic [1:0]  mode;
        logic [1:0]  prev;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   flush_n, strobe_n, commit_at, idle_at;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [2:0] strobe, input logic nextm, input logic chk_cause,
                        input logic [63:0] cause, input logic [63:0] pc,
                        input logic [1:0] mode, input logic [1:0] prev);
        exp_t e;
        e.strobe = strobe; e.nextm = nextm; e.chk_cause = chk_cause; e.cause = cause;
        e.pc = pc; e.mode = mode; e.prev = prev;
        exp_q.push_back(e);
    endtask

    // Requests are already driven in IDLE; the next edge samples them.
    task automatic run_seq(input int pipe_low, input int stall_commit,
                           input bit keep_mret, input bit ready);
        exp_t e;
        int   cyc;
        bit   mode_moved;
        chk("queue_nonempty", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        RedirectReady = ready;
        StallW    = 1'b0;
        PipeEmpty = (pipe_low <= 0);
        tick();
        cyc = 1;
        TrapReqM = 1'b0; SretReqM = 1'b0; InterruptM = 1'b0;
        if (!keep_mret) MretReqM = 1'b0;
        flush_n = 0;
        while (!(TrapM | mretM | sretM) && cyc < 40) begin
            if (FlushReq) flush_n++;
            PipeEmpty = (cyc >= pipe_low);
            tick();
            cyc++;
        end
        PipeEmpty = 1'b1;
        commit_at = cyc;
        chk("strobe_kind", {61'd0, TrapM, mretM, sretM}, {61'd0, e.strobe});
        chk("next_is_m", {63'd0, NextPrivModeIsM}, {63'd0, e.nextm});
        if (e.chk_cause) chk("trap_cause", TrapCauseM, e.cause);
        chk("mode_before_commit", {62'd0, PrivilegeModeW}, {62'd0, e.prev});
        strobe_n = 0;
        mode_moved = 1'b0;
        while ((TrapM | mretM | sretM) && strobe_n < 40) begin
            StallW = (strobe_n < stall_commit);
            if (PrivilegeModeW !== e.prev) mode_moved = 1'b1;
            strobe_n++;
            tick();
            cyc++;
        end
        StallW = 1'b0;
        chk("mode_held_in_commit", {63'd0, mode_moved}, 64'd0);
        chk("redirect_valid", {63'd0, RedirectValid}, 64'd1);
        chk("redirect_pc", RedirectPC, e.pc);
        chk("mode_after_commit", {62'd0, PrivilegeModeW}, {62'd0, e.mode});
        if (ready) begin
            tick();
            cyc++;
            idle_at = cyc;
            chk("busy_after", {63'd0, Busy}, 64'd0);
        end
    endtask

    initial begin
        #12;
        chk("rst_mode", {62'd0, PrivilegeModeW}, 64'd3);
        chk("rst_outs", {56'd0, TrapM, mretM, sretM, NextPrivModeIsM, FlushReq,
                         RedirectValid, Busy, 1'b0}, 64'd0);
        chk("rst_cause", TrapCauseM, 64'd0);
        chk("rst_pc", RedirectPC, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        MEDELEG_REGW = 16'h0120;
        MIDELEG_REGW = 12'h0A0;
        MTVEC_REGW   = 64'h1001;
        STVEC_REGW   = 64'h8000_0001;

        // mret from M to U
        MretReqM = 1'b1; STATUS_MPP = 2'b00; MEPC_REGW = 64'h4000;
        push(3'b010, 1'b0, 1'b0, 64'd0, 64'h4000, 2'b00, 2'b11);
        run_seq(0, 0, 1'b0, 1'b1);

        // ecall from U, delegated to S, minimum latency
        TrapReqM = 1'b1; CauseM = 4'd8;
        push(3'b100, 1'b0, 1'b1, 64'd8, 64'h8000_0000, 2'b01, 2'b00);
        run_seq(0, 0, 1'b0, 1'b1);
        chk("lat_commit", 64'(commit_at), 64'd2);
        chk("lat_idle", 64'(idle_at), 64'd4);
        chk("lat_flush", 64'(flush_n), 64'd1);

        // sret in S with TSR set becomes an illegal-instruction trap to M
        SretReqM = 1'b1; STATUS_TSR = 1'b1; STATUS_SPP = 1'b1; SEPC_REGW = 64'h6000;
        push(3'b100, 1'b1, 1'b1, 64'd2, 64'h1000, 2'b11, 2'b01);
        run_seq(0, 0, 1'b0, 1'b1);

        // vectored timer interrupt taken in M
        TrapReqM = 1'b1; InterruptM = 1'b1; CauseM = 4'd7;
        push(3'b100, 1'b1, 1'b1, 64'h8000_0000_0000_0007, 64'h101C, 2'b11, 2'b11);
        run_seq(0, 0, 1'b0, 1'b1);

        // simultaneous trap and mret: trap first, held mret afterwards
        MTVEC_REGW = 64'h2000;
        TrapReqM = 1'b1; CauseM = 4'd3; MretReqM = 1'b1;
        STATUS_MPP = 2'b01; MEPC_REGW = 64'h5000;
        push(3'b100, 1'b1, 1'b1, 64'd3, 64'h2000, 2'b11, 2'b11);
        run_seq(0, 0, 1'b1, 1'b1);
        push(3'b010, 1'b0, 1'b0, 64'd0, 64'h5000, 2'b01, 2'b11);
        run_seq(0, 0, 1'b0, 1'b1);

        // delegated trap from S with a slow drain and a stalled commit
        TrapReqM = 1'b1; CauseM = 4'd5;
        push(3'b100, 1'b0, 1'b1, 64'd5, 64'h8000_0000, 2'b01, 2'b01);
        run_seq(5, 2, 1'b0, 1'b1);
        chk("stall_flush", 64'(flush_n), 64'd5);
        chk("stall_strobe", 64'(strobe_n), 64'd3);

        // asynchronous reset while parked in REDIRECT
        TrapReqM = 1'b1; CauseM = 4'd8;
        push(3'b100, 1'b0, 1'b1, 64'd8, 64'h8000_0000, 2'b01, 2'b01);
        run_seq(0, 0, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk("arst_mode", {62'd0, PrivilegeModeW}, 64'd3);
        chk("arst_rv", {63'd0, RedirectValid}, 64'd0);
        chk("arst_busy", {63'd0, Busy}, 64'd0);
        chk("arst_pc", RedirectPC, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        RedirectReady = 1'b1;
        tick();

        // sret from M is legal regardless of TSR
        SretReqM = 1'b1; STATUS_SPP = 1'b1; STATUS_TSR = 1'b1;
        push(3'b001, 1'b0, 1'b0, 64'd0, 64'h6000, 2'b01, 2'b11);
        run_seq(0, 0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/privtrapseq.md
# privtrapseq

Privilege-transition sequencer for the CSR/privileged unit. It owns the current privilege-mode register. It serializes trap entry, `mret` and `sret` into a drain → commit → redirect sequence, and resolves M/S delegation and illegal returns. It issues the one-cycle commit strobes that the status-register block consumes: `TrapM`, `mretM`, `sretM`, `NextPrivModeIsM`.

## Interface
Parameters:
- `XLEN`, 64, datapath width (32 or 64)
- `S_SUPPORTED`, 1, supervisor mode present
- `U_SUPPORTED`, 1, user mode present

Ports:
- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-low reset
- `TrapReqM`  in  1  exception/interrupt request (level)
- `InterruptM`  in  1  request is an interrupt
- `CauseM`  in  4  cause code
- `MretReqM`, `SretReqM`  in  1  return requests (level)
- `STATUS_MPP`  in  2  status field
- `STATUS_SPP`, `STATUS_TSR`  in  1  status fields
- `MEDELEG_REGW`  in  16  exception delegation bits
- `MIDELEG_REGW`  in  12  interrupt delegation bits
- `MTVEC_REGW`, `STVEC_REGW`, `MEPC_REGW`, `SEPC_REGW`  in  XLEN  vectors and return PCs
- `PipeEmpty`  in  1  no older instructions or memory ops outstanding
- `StallW`  in  1  writeback stall
- `RedirectReady`  in  1  fetch accepts the redirect
- `PrivilegeModeW`  out  2  current privilege mode
- `TrapM`, `mretM`, `sretM`  out  1  commit strobes
- `NextPrivModeIsM`  out  1  trap target is M
- `TrapCauseM`  out  XLEN  cause for the mcause/scause write: `{Interrupt, 0…, cause}`
- `FlushReq`  out  1  pipeline flush request
- `RedirectValid`  out  1  redirect PC valid
- `RedirectPC`  out  XLEN  redirect target
- `Busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, DRAIN, COMMIT, REDIRECT. `Busy` = (state ≠ IDLE).
- Requests are sampled only in IDLE. Priority is trap > mret > sret. The kind, cause, interrupt flag, target mode and target PC are captured at that sample. Requests arriving outside IDLE are ignored; requesters hold them until the sequencer returns to IDLE.
- Illegal returns convert to a trap with interrupt = 0 and cause = 2:
  - `mret` with PrivilegeModeW ≠ M.
  - `sret` with PrivilegeModeW = U.
  - `sret` with PrivilegeModeW = S and `STATUS_TSR` = 1.
- Trap delegation: the target is S when all of the following hold; otherwise the target is M.
  - S_SUPPORTED = 1.
  - PrivilegeModeW ≠ M.
  - The delegation bit at index `CauseM` is set: `MIDELEG_REGW` for interrupts, `MEDELEG_REGW` otherwise. A cause ≥ 12 for an interrupt is never delegated.
- Trap PC: base = `{tvec[XLEN-1:2], 2'b00}`, where tvec is the selected MTVEC/STVEC. If `InterruptM` = 1 and tvec[1:0] = 01, PC = base + 4·cause; otherwise PC = base.
- `mret`: next mode = `STATUS_MPP`, mapped to M if that mode is unsupported. PC = `MEPC_REGW`.
- `sret`: next mode = `{1'b0, STATUS_SPP}`. PC = `SEPC_REGW`.
- DRAIN: `FlushReq` = 1. Exit to COMMIT when `PipeEmpty` & ~`StallW`.
- COMMIT: exactly one of `TrapM`/`mretM`/`sretM` is high. `NextPrivModeIsM` and `TrapCauseM` are valid. COMMIT is held while `StallW` = 1. On the first edge with `StallW` = 0:
  - PrivilegeModeW takes the captured next mode.
  - The state moves to REDIRECT.
- REDIRECT: `RedirectValid` = 1 with `RedirectPC` stable. Return to IDLE on the edge where `RedirectReady` = 1.

## Timing
- Reset (asynchronous, active-low) sets state = IDLE and PrivilegeModeW = 2'b11. All other outputs are 0, including `TrapCauseM` and `RedirectPC`. Reset asserted mid-sequence aborts the sequence with no strobe and no privilege change.
- Minimum latency:
  - Request sampled in IDLE at cycle 0.
  - DRAIN at cycle 1.
  - COMMIT at cycle 2, given `PipeEmpty` & ~`StallW` at cycle 1.
  - REDIRECT at cycle 3; PrivilegeModeW changes at the start of cycle 3.
  - IDLE at cycle 4 if `RedirectReady` is high at cycle 3.
- The strobes are combinational decodes of state = COMMIT and are never high outside COMMIT. They may stay high for several cycles under `StallW`; the status register only acts when ~`StallW`.
- `RedirectPC` and `TrapCauseM` come from registers and are held from capture until the next capture.
- PrivilegeModeW changes only on the COMMIT→REDIRECT edge.

## Test plan
- Ecall from U (cause 8), MEDELEG[8] = 1, STVEC = 0x8000_0001 → TrapM = 1, NextPrivModeIsM = 0, RedirectPC = 0x8000_0000, PrivilegeModeW = 01 after commit, 4-cycle minimum latency.
- Timer interrupt (cause 7) from M, MTVEC = 0x1001 → M target, RedirectPC = 0x101C, TrapCauseM MSB = 1.
- `sret` in S with TSR = 1 → trap with cause 2 to M, `sretM` never asserted, RedirectPC = MTVEC base.
- TrapReqM and MretReqM high together in IDLE → trap taken. MretReqM still held afterwards → `mret` sequence runs after return to IDLE.
- PipeEmpty low for 5 cycles, then StallW high for 2 cycles in COMMIT → FlushReq high for 5 cycles, TrapM high for 3 cycles, single privilege update.
- Reset pulsed low during REDIRECT after an S-mode trap → PrivilegeModeW = 11, RedirectValid = 0, Busy = 0 immediately (asynchronous).
